// File: rtl/song_pkg.sv
// Shared types and widths for the song sequencer: state encoding,
// bus widths and the note-length helper.
`timescale 1ns/1ps
package song_pkg;

  localparam int unsigned CLOCK_FREQ_DEFAULT = 100_000_000;
  localparam int PERIOD_W   = 20;
  localparam int DURATION_W = 5;
  localparam int INDEX_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SOUND = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } song_state_e;

  // Note length in clock cycles: duration (quarter seconds) times cycles per quarter.
  function automatic logic [31:0] note_ticks(input logic [DURATION_W-1:0] duration,
                                             input logic [31:0] quarter);
    return {{(32-DURATION_W){1'b0}}, duration} * quarter;
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Bus between the sequencer, its music-sheet ROM and the tone generator.
// master = sequencer side, slave = sheet/player side.
`timescale 1ns/1ps
interface song_sequencer_if;

  logic                            play;
  logic                            loop;
  logic [song_pkg::INDEX_W-1:0]    rom_addr;
  logic [song_pkg::PERIOD_W-1:0]   rom_period;
  logic [song_pkg::DURATION_W-1:0] rom_duration;
  logic [song_pkg::PERIOD_W-1:0]   note_period;
  logic                            note_valid;
  logic                            note_start;
  logic                            busy;
  logic                            done;

  modport master (
    input  play, loop, rom_period, rom_duration,
    output rom_addr, note_period, note_valid, note_start, busy, done
  );

  modport slave (
    output play, loop, rom_period, rom_duration,
    input  rom_addr, note_period, note_valid, note_start, busy, done
  );

endinterface

// File: rtl/song_sequencer_note_timer.sv
// Loadable 32-bit down-counter timing both the sounding part and the
// articulation gap of a note. Load wins over enable; it stops at zero.
`timescale 1ns/1ps
module note_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] load_value,
  output logic        zero
);

  logic [31:0] count_r;

  // Counter register: load, count down while enabled, hold otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= 32'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != 32'd0)) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 32'd0);

endmodule

// File: rtl/song_sequencer.sv
// Steps through a music sheet ROM, presenting each note's half-period to a
// tone generator for its duration minus a short silent articulation gap.
`timescale 1ns/1ps
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = CLOCK_FREQ_DEFAULT,
  parameter int unsigned SONG_LEN   = 45,
  parameter int unsigned GAP_CYCLES = 5_000_000
) (
  input  logic             clock,
  input  logic             reset,
  song_sequencer_if.master bus
);

  localparam logic [31:0] QUARTER    = 32'(CLOCK_FREQ / 4);
  // Timer counts N-1..0 for an N-cycle phase; FETCH takes the extra cycle.
  localparam logic [31:0] SOUND_TRIM = 32'(GAP_CYCLES + 2);
  localparam logic [31:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [INDEX_W-1:0] LAST_ADDR = INDEX_W'(SONG_LEN - 1);
  localparam logic [INDEX_W-1:0] END_ADDR  = INDEX_W'(SONG_LEN);

  song_state_e         state_r, state_s;
  logic [INDEX_W-1:0]  addr_r, addr_s, next_addr_s;
  logic [PERIOD_W-1:0] period_r, period_s;
  logic                valid_r, start_r, busy_r, done_r;
  logic                timer_load_s, timer_en_s, timer_zero_s;
  logic [31:0]         timer_value_s, ticks_s;
  logic                end_fetch_s;

  assign ticks_s     = note_ticks(bus.rom_duration, QUARTER);
  assign end_fetch_s = (bus.rom_duration == {DURATION_W{1'b0}}) || (addr_r >= END_ADDR);
  // Wrapping at the last entry avoids spending a fetch on the past-the-end slot,
  // so a looping song repeats with no extra cycle between passes.
  assign next_addr_s = ((addr_r == LAST_ADDR) && bus.loop) ? {INDEX_W{1'b0}}
                                                           : addr_r + {{(INDEX_W-1){1'b0}}, 1'b1};

  note_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load_s),
    .enable     (timer_en_s),
    .load_value (timer_value_s),
    .zero       (timer_zero_s)
  );

  // Next-state, next-index, note latch and timer control; play low overrides all.
  always_comb begin
    state_s       = state_r;
    addr_s        = addr_r;
    period_s      = period_r;
    timer_load_s  = 1'b0;
    timer_en_s    = 1'b0;
    timer_value_s = 32'd0;
    if (!bus.play) begin
      state_s      = ST_IDLE;
      addr_s       = {INDEX_W{1'b0}};
      period_s     = {PERIOD_W{1'b0}};
      timer_load_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_FETCH;
          addr_s  = {INDEX_W{1'b0}};
        end
        ST_FETCH: begin
          if (end_fetch_s) begin
            if (bus.loop) begin
              state_s = ST_FETCH;
              addr_s  = {INDEX_W{1'b0}};
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            state_s       = ST_SOUND;
            period_s      = bus.rom_period;
            timer_load_s  = 1'b1;
            timer_value_s = ticks_s - SOUND_TRIM;
          end
        end
        ST_SOUND: begin
          if (timer_zero_s) begin
            if (GAP_CYCLES == 0) begin
              state_s = ST_FETCH;
              addr_s  = next_addr_s;
            end else begin
              state_s       = ST_GAP;
              timer_load_s  = 1'b1;
              timer_value_s = GAP_LOAD;
            end
          end else begin
            timer_en_s = 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_zero_s) begin
            state_s = ST_FETCH;
            addr_s  = next_addr_s;
          end else begin
            timer_en_s = 1'b1;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; flags are decoded from the upcoming state so they
  // line up with it, except done which is a registered decode of the settled state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      addr_r   <= {INDEX_W{1'b0}};
      period_r <= {PERIOD_W{1'b0}};
      valid_r  <= 1'b0;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      period_r <= period_s;
      valid_r  <= (state_s == ST_SOUND) && (period_s != {PERIOD_W{1'b0}});
      start_r  <= (state_s == ST_SOUND) && (state_r == ST_FETCH);
      busy_r   <= (state_s == ST_FETCH) || (state_s == ST_SOUND) || (state_s == ST_GAP);
      done_r   <= (state_r == ST_DONE) && bus.play;
    end
  end

  assign bus.rom_addr    = addr_r;
  assign bus.note_period = period_r;
  assign bus.note_valid  = valid_r;
  assign bus.note_start  = start_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with a 3-entry sheet, 100-cycle quarters and a
// 10-cycle gap. Note starts go through a scoreboard queue; per-song
// expectations come from a vector table; stop/restart and reset are hand-driven.
`timescale 1ns/1ps
module tb_song_sequencer;

  localparam int QUARTER = 100;

  typedef struct {
    int p0; int d0; int p1; int d1; int p2; int d2;
    logic        loop;
    int          window;
    int          probe_rel;
    logic        probe_valid;
    logic [19:0] probe_period;
    logic        probe_busy;
    int          done_rel;     // 0: done must never assert within the window
    logic [9:0]  final_addr;
  } vec_t;

  typedef struct {
    int          rel;
    logic [19:0] period;
  } exp_t;

  logic clock;
  logic reset;
  logic [19:0] sheet_p [4];
  logic [4:0]  sheet_d [4];
  exp_t sbq [$];
  vec_t vecs [4];
  int checks;
  int failures;
  int rel;

  song_sequencer_if bus();

  song_sequencer #(
    .CLOCK_FREQ (400),
    .SONG_LEN   (3),
    .GAP_CYCLES (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_period   = (bus.rom_addr < 10'd4) ? sheet_p[bus.rom_addr[1:0]] : 20'd0;
  assign bus.rom_duration = (bus.rom_addr < 10'd4) ? sheet_d[bus.rom_addr[1:0]] : 5'd0;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (rel=%0d)", name, act, exp, rel);
    end
  endtask

  // One clock; sample 1 ns after the edge and match any note_start against the queue.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    rel++;
    if (bus.note_start === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_note_start actual=1 required=0 (rel=%0d)", rel);
      end else begin
        e = sbq.pop_front();
        check("start_rel", rel, e.rel);
        check("start_period", {12'd0, bus.note_period}, {12'd0, e.period});
      end
    end
  endtask

  task automatic load_sheet(input int p0, input int d0, input int p1, input int d1,
                            input int p2, input int d2);
    sheet_p[0] = 20'(p0); sheet_d[0] = 5'(d0);
    sheet_p[1] = 20'(p1); sheet_d[1] = 5'(d1);
    sheet_p[2] = 20'(p2); sheet_d[2] = 5'(d2);
    sheet_p[3] = 20'd0;   sheet_d[3] = 5'd0;
  endtask

  // Expected note starts: first at rel 1, each next one a full note length later.
  task automatic push_song(input vec_t v);
    int t;
    int pp [3];
    int dd [3];
    logic ended;
    pp = '{v.p0, v.p1, v.p2};
    dd = '{v.d0, v.d1, v.d2};
    t = 1;
    for (int it = 0; it < 8; it++) begin
      ended = 1'b0;
      for (int e = 0; e < 3; e++) begin
        if (!ended) begin
          if (dd[e] == 0) begin
            ended = 1'b1;
          end else begin
            if (t <= v.window) sbq.push_back('{t, 20'(pp[e])});
            t = t + dd[e] * QUARTER;
          end
        end
      end
      if (ended) t = t + 1;
      if (!v.loop || t > v.window) break;
    end
  endtask

  function automatic vec_t mk(input int p0, input int d0, input int p1, input int d1,
                              input int p2, input int d2, input logic lp, input int window,
                              input int probe_rel, input logic pv, input int pp, input logic pb,
                              input int done_rel, input int final_addr);
    vec_t v;
    v.p0 = p0; v.d0 = d0; v.p1 = p1; v.d1 = d1; v.p2 = p2; v.d2 = d2;
    v.loop = lp; v.window = window;
    v.probe_rel = probe_rel; v.probe_valid = pv; v.probe_period = 20'(pp); v.probe_busy = pb;
    v.done_rel = done_rel; v.final_addr = 10'(final_addr);
    return v;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_rom_addr"},    {22'd0, bus.rom_addr}, 32'd0);
    check({tag, "_note_period"}, {12'd0, bus.note_period}, 32'd0);
    check({tag, "_note_valid"},  {31'd0, bus.note_valid}, 32'd0);
    check({tag, "_note_start"},  {31'd0, bus.note_start}, 32'd0);
    check({tag, "_busy"},        {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"},        {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    clock = 1'b0;
    checks = 0;
    failures = 0;
    rel = 0;
    load_sheet(0, 0, 0, 0, 0, 0);
    //        p0 d0  p1 d1  p2 d2 loop win  probe valid per busy done addr
    vecs[0] = mk(50, 2, 30, 1, 40, 1, 1'b0, 420, 100, 1'b1, 50, 1'b1, 402, 3);
    vecs[1] = mk(50, 2, 30, 1, 40, 1, 1'b1, 950, 395, 1'b0, 40, 1'b1, 0,   0);
    vecs[2] = mk(50, 1, 0,  1, 40, 1, 1'b0, 320, 150, 1'b0, 0,  1'b1, 302, 3);
    vecs[3] = mk(50, 2, 30, 0, 40, 1, 1'b0, 220, 195, 1'b0, 50, 1'b1, 202, 1);

    // Reset overrides play.
    reset = 1'b0;
    bus.play = 1'b1;
    bus.loop = 1'b0;
    step();
    check_cleared("reset");
    reset = 1'b1;
    bus.play = 1'b0;
    step();
    step();

    for (int i = 0; i < 4; i++) begin
      bus.play = 1'b0;
      step();
      step();
      load_sheet(vecs[i].p0, vecs[i].d0, vecs[i].p1, vecs[i].d1, vecs[i].p2, vecs[i].d2);
      bus.loop = vecs[i].loop;
      sbq.delete();
      push_song(vecs[i]);
      rel = -1;
      bus.play = 1'b1;
      while (rel < vecs[i].window) begin
        step();
        if (rel == vecs[i].probe_rel) begin
          check($sformatf("v%0d_probe_valid", i), {31'd0, bus.note_valid}, {31'd0, vecs[i].probe_valid});
          check($sformatf("v%0d_probe_period", i), {12'd0, bus.note_period}, {12'd0, vecs[i].probe_period});
          check($sformatf("v%0d_probe_busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].probe_busy});
        end
        if (vecs[i].done_rel != 0 && rel == vecs[i].done_rel - 1)
          check($sformatf("v%0d_done_early", i), {31'd0, bus.done}, 32'd0);
        if (vecs[i].done_rel != 0 && rel == vecs[i].done_rel)
          check($sformatf("v%0d_done", i), {31'd0, bus.done}, 32'd1);
      end
      if (vecs[i].done_rel == 0)
        check($sformatf("v%0d_done_never", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("v%0d_final_addr", i), {22'd0, bus.rom_addr}, {22'd0, vecs[i].final_addr});
      check($sformatf("v%0d_missing_starts", i), sbq.size(), 32'd0);
    end

    // Stop 50 cycles into entry 1, then restart: must begin again at entry 0.
    bus.play = 1'b0;
    step();
    load_sheet(50, 2, 30, 1, 40, 1);
    bus.loop = 1'b0;
    sbq.delete();
    sbq.push_back('{1, 20'd50});
    sbq.push_back('{201, 20'd30});
    rel = -1;
    bus.play = 1'b1;
    while (rel < 250) step();
    bus.play = 1'b0;
    step();
    check_cleared("stop");
    repeat (5) step();
    sbq.delete();
    sbq.push_back('{1, 20'd50});
    rel = -1;
    bus.play = 1'b1;
    step();
    check("restart_rom_addr", {22'd0, bus.rom_addr}, 32'd0);
    check("restart_busy", {31'd0, bus.busy}, 32'd1);
    step();
    check("restart_missing_start", sbq.size(), 32'd0);

    // Reset pulse mid-SOUND with play held high.
    while (rel < 100) step();
    check("pre_reset_valid", {31'd0, bus.note_valid}, 32'd1);
    reset = 1'b0;
    step();
    check_cleared("midreset");
    reset = 1'b1;
    sbq.delete();
    sbq.push_back('{1, 20'd50});
    rel = -1;
    step();
    check("post_reset_rom_addr", {22'd0, bus.rom_addr}, 32'd0);
    repeat (5) step();
    check("post_reset_missing_start", sbq.size(), 32'd0);
    check("post_reset_valid", {31'd0, bus.note_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
